lsu_sq: RTL and testbench
=========================

// Module: lsu_sq
// PURPOSE
//  Store queue: holds issued stores in program order until ROB retirement, then drains them in order to the D-cache write port.
//  Each drained store is broadcast (addr/width) to the load queue for mis-speculation detection. Sits in the LSU beside the LQ.
// PARAMETERS
//  DATA_WIDTH  32  store data / memory word width (bits); power of 2, >=16
//  ADDR_WIDTH  32  address width
//  TAG_WIDTH   6   ROB tag width
//  SQ_DEPTH    8   entries; power of 2
// PORTS
//  clk                 in   1              clock
//  rst                 in   1              asynchronous, active-high reset
//  i_flush             in   1              discard all non-retired stores
//  o_full              out  1              no free entry (registered count == SQ_DEPTH)
//  i_alloc_tag         in   TAG_WIDTH      ROB tag of new store
//  i_alloc_addr        in   ADDR_WIDTH     byte address
//  i_alloc_data        in   DATA_WIDTH     store data, right-justified
//  i_alloc_width       in   4              bytes: 1, 2 or 4
//  i_alloc_en          in   1              allocate at tail
//  i_rob_retire_tag    in   TAG_WIDTH      tag of retiring store
//  i_rob_retire_en     in   1              mark matching entry committed
//  o_mem_wr_addr       out  ADDR_WIDTH     word-aligned address (low log2(DATA_WIDTH/8) bits zero)
//  o_mem_wr_data       out  DATA_WIDTH     data shifted into byte lanes
//  o_mem_wr_byte_en    out  DATA_WIDTH/8   lane byte enables
//  o_mem_wr_valid      out  1              write request
//  i_mem_wr_ready      in   1              cache accepts write
//  o_sq_retire_addr    out  ADDR_WIDTH     unaligned address of drained store (to LQ)
//  o_sq_retire_width   out  4              width of drained store (to LQ)
//  o_sq_retire_en      out  1              one-cycle pulse per drained store
// BEHAVIOUR
//  Reset: head=tail=count=retired_count=0, all valid/retired clear, state IDLE; every output 0.
//  Circular FIFO: alloc writes tail, tail++ (mod SQ_DEPTH), count++. Alloc while o_full: dropped, no state change.
//  Retire: valid, non-retired entry with tag match sets retired, retired_count++; no match -> ignored.
//   ROB retires in order, so retired entries are contiguous from head.
//  FSM IDLE: head valid & retired -> WRITE; mem outputs registered from head entry; o_mem_wr_valid=1 next cycle.
//  FSM WRITE: hold valid/addr/data/byte_en stable until i_mem_wr_ready.
//   On handshake: pop head (head++, count--, retired_count--), next state IDLE.
//   Next cycle: o_sq_retire_en=1 with o_sq_retire_addr/width of the popped entry.
//  Lane align: byte_en = ((1<<width)-1) << off, data << 8*off, off = addr[log2(DATA_WIDTH/8)-1:0]. Word-crossing stores: undefined.
//  Min drain latency: retire at cycle N -> o_mem_wr_valid at N+2 (entry at head, ready=1).
//  Flush: clear valid on non-retired entries; tail <= head + retired_count; count <= retired_count.
//   Retired entries and an in-flight WRITE are unaffected.
//  Same-cycle events:
//   flush+alloc -> alloc dropped; flush+retire -> retire applied first, entry survives;
//   alloc+pop when not full -> count unchanged; pop and flush -> pop accounted before flush.
//  rst mid-WRITE: request dropped asynchronously, contents lost.
// CONFIGURATION
//  LSU_SQ_B2B_DRAIN_EN defined: WRITE handshake with next head retired -> stay in WRITE, load next entry (one store/cycle).
//  Not defined: always return to IDLE (one bubble, max one store per 2 cycles).
// STRUCTURE
//  Package types: sq_slot_t {addr, data, width, tag, valid, retired}, sq_state_t {SQ_IDLE, SQ_WRITE}, width constants.
//  Sub-module lsu_sq_lane_align: addr/width/data -> aligned addr, shifted data, byte_en.
// TESTING
//  Reset held -> o_full=0, o_mem_wr_valid=0, o_sq_retire_en=0.
//  Alloc tag3 addr 0x1002 data 0xABCD width2; retire tag3; ready=1
//   -> wr_addr 0x1000, data 0xABCD0000, byte_en 4'b1100; next cycle retire_en=1, addr 0x1002, width 2.
//  8 allocs -> o_full=1; 9th alloc dropped; retire+drain one -> o_full=0, next alloc accepted.
//  ready=0 for 5 cycles during WRITE -> valid/addr/data/byte_en stable, no retire_en; ready=1 -> single pop.
//  2 retired + 3 non-retired, flush -> exactly 2 writes in order; next alloc occupies slot head+2.
//  20 alloc/retire/drain rounds (wrap) -> write order equals alloc order.
//  With LSU_SQ_B2B_DRAIN_EN: 2 retired, ready=1 -> writes in consecutive cycles.

Source files
------------

// File: rtl/lsu_sq_pkg.sv
// Store queue shared types: slot record, drain FSM states, store width codes.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lsu_sq_pkg;

  // Slot field widths; lsu_sq parameters default to these and must stay in step.
  localparam int SQ_DATA_W = 32;
  localparam int SQ_ADDR_W = 32;
  localparam int SQ_TAG_W  = 6;

  // Store width encodings (bytes).
  localparam logic [3:0] SQ_W_BYTE = 4'd1;
  localparam logic [3:0] SQ_W_HALF = 4'd2;
  localparam logic [3:0] SQ_W_WORD = 4'd4;

  typedef enum logic {
    SQ_IDLE  = 1'b0,
    SQ_WRITE = 1'b1
  } sq_state_t;

  typedef struct packed {
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    logic [3:0]           width;
    logic [SQ_TAG_W-1:0]  tag;
    logic                 valid;
    logic                 retired;
  } sq_slot_t;

endpackage

// File: rtl/lsu_sq_lane_align.sv
// Lane aligner: byte address/width/right-justified data -> word address, lane data, byte enables.
// Latency: combinational.
// Backpressure: none (pure function).
// Ports: addr/width/data in; aligned_addr, lane_data, byte_en out.
module lsu_sq_lane_align #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [3:0]              width,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [ADDR_WIDTH-1:0]   aligned_addr,
  output logic [DATA_WIDTH-1:0]   lane_data,
  output logic [DATA_WIDTH/8-1:0] byte_en
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BE_W);

  logic [OFF_W-1:0] off;
  logic [BE_W-1:0]  mask;

  assign off          = addr[OFF_W-1:0];
  assign aligned_addr = {addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // (1 << width) - 1, built bitwise so it never overflows BE_W.
  always_comb begin
    mask = '0;
    for (int i = 0; i < BE_W; i++) mask[i] = (i < int'(width));
  end

  // Word-crossing stores simply lose their upper bytes off the top.
  assign lane_data = data << {off, 3'b000};
  assign byte_en   = mask << off;

endmodule

// File: rtl/lsu_sq.sv
// Store queue: holds stores in program order, drains ROB-retired ones in order to the D-cache, tells LQ.
// Latency: retire at cycle N -> o_mem_wr_valid at N+2; o_sq_retire_en the cycle after the handshake.
// Backpressure: write request held stable until i_mem_wr_ready; allocs dropped while o_full.
// Ports: alloc (tag/addr/data/width/en), ROB retire (tag/en), flush, D-cache write (addr/data/byte_en/valid/ready),
//        LQ broadcast (sq_retire addr/width/en), o_full.
// Config: LSU_SQ_B2B_DRAIN_EN lets a handshake roll straight into the next retired store (one store/cycle).
module lsu_sq
  import lsu_sq_pkg::*;
#(
  parameter int DATA_WIDTH = SQ_DATA_W,
  parameter int ADDR_WIDTH = SQ_ADDR_W,
  parameter int TAG_WIDTH  = SQ_TAG_W,
  parameter int SQ_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  output logic                    o_full,
  input  logic [TAG_WIDTH-1:0]    i_alloc_tag,
  input  logic [ADDR_WIDTH-1:0]   i_alloc_addr,
  input  logic [DATA_WIDTH-1:0]   i_alloc_data,
  input  logic [3:0]              i_alloc_width,
  input  logic                    i_alloc_en,
  input  logic [TAG_WIDTH-1:0]    i_rob_retire_tag,
  input  logic                    i_rob_retire_en,
  output logic [ADDR_WIDTH-1:0]   o_mem_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wr_data,
  output logic [DATA_WIDTH/8-1:0] o_mem_wr_byte_en,
  output logic                    o_mem_wr_valid,
  input  logic                    i_mem_wr_ready,
  output logic [ADDR_WIDTH-1:0]   o_sq_retire_addr,
  output logic [3:0]              o_sq_retire_width,
  output logic                    o_sq_retire_en
);
  localparam int PTR_W = $clog2(SQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  sq_slot_t         slots [SQ_DEPTH];
  logic [PTR_W-1:0] head, tail, ld_idx, tail_nxt;
  logic [CNT_W-1:0] count, retired_count, rc_nxt, count_nxt;
  sq_state_t        state, state_nxt;
  logic             load, pop, alloc_ok, ret_hit;
  logic [PTR_W-1:0] ret_idx;

  logic [ADDR_WIDTH-1:0] al_addr;
  logic [DATA_WIDTH-1:0] al_data;
  logic [BE_W-1:0]       al_be;

  assign o_full   = (count == CNT_W'(SQ_DEPTH));
  assign alloc_ok = i_alloc_en && !o_full && !i_flush;

  // Tags are unique among live stores; lowest index wins just to keep the search well defined.
  always_comb begin
    ret_hit = 1'b0;
    ret_idx = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      if (!ret_hit && i_rob_retire_en && slots[i].valid && !slots[i].retired &&
          slots[i].tag == i_rob_retire_tag) begin
        ret_hit = 1'b1;
        ret_idx = PTR_W'(i);
      end
    end
  end

  // Drain FSM: IDLE loads the head once retired; WRITE holds until the cache accepts.
`ifdef LSU_SQ_B2B_DRAIN_EN
  logic [PTR_W-1:0] head_p1;
  assign head_p1 = head + 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    pop       = 1'b0;
    ld_idx    = head;
    unique case (state)
      SQ_IDLE: begin
        if (slots[head].valid && slots[head].retired) begin
          state_nxt = SQ_WRITE;
          load      = 1'b1;
        end
      end
      SQ_WRITE: begin
        if (i_mem_wr_ready) begin
          pop       = 1'b1;
          state_nxt = SQ_IDLE;
`ifdef LSU_SQ_B2B_DRAIN_EN
          ld_idx = head_p1;
          if (slots[head_p1].valid && slots[head_p1].retired) begin
            state_nxt = SQ_WRITE;
            load      = 1'b1;
          end
`endif
        end
      end
      default: state_nxt = SQ_IDLE;
    endcase
  end

  lsu_sq_lane_align #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_align (
    .addr         (slots[ld_idx].addr),
    .width        (slots[ld_idx].width),
    .data         (slots[ld_idx].data),
    .aligned_addr (al_addr),
    .lane_data    (al_data),
    .byte_en      (al_be)
  );

  // Pop and retire are folded in before flush, so flush keeps exactly the surviving retired run.
  always_comb begin
    rc_nxt = retired_count + CNT_W'(ret_hit) - CNT_W'(pop);
    if (i_flush) begin
      tail_nxt  = (head + PTR_W'(pop)) + rc_nxt[PTR_W-1:0];
      count_nxt = rc_nxt;
    end else begin
      tail_nxt  = tail + PTR_W'(alloc_ok);
      count_nxt = count + CNT_W'(alloc_ok) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SQ_IDLE;
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      retired_count <= '0;
    end else begin
      state         <= state_nxt;
      head          <= head + PTR_W'(pop);
      tail          <= tail_nxt;
      count         <= count_nxt;
      retired_count <= rc_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SQ_DEPTH; i++) slots[i] <= '0;
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (i_flush && slots[i].valid && !slots[i].retired && !(ret_hit && ret_idx == PTR_W'(i)))
          slots[i].valid <= 1'b0;
      end
      if (ret_hit) slots[ret_idx].retired <= 1'b1;
      if (pop) begin
        slots[head].valid   <= 1'b0;
        slots[head].retired <= 1'b0;
      end
      if (alloc_ok)
        slots[tail] <= '{addr: i_alloc_addr, data: i_alloc_data, width: i_alloc_width,
                         tag: i_alloc_tag, valid: 1'b1, retired: 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mem_wr_addr     <= '0;
      o_mem_wr_data     <= '0;
      o_mem_wr_byte_en  <= '0;
      o_mem_wr_valid    <= 1'b0;
      o_sq_retire_addr  <= '0;
      o_sq_retire_width <= '0;
      o_sq_retire_en    <= 1'b0;
    end else begin
      o_sq_retire_en <= pop;
      if (pop) begin
        o_sq_retire_addr  <= slots[head].addr;
        o_sq_retire_width <= slots[head].width;
      end
      if (load) begin
        o_mem_wr_addr    <= al_addr;
        o_mem_wr_data    <= al_data;
        o_mem_wr_byte_en <= al_be;
        o_mem_wr_valid   <= 1'b1;
      end else if (pop) begin
        o_mem_wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_sq.sv
module tb_lsu_sq;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_flush = 1'b0;
  logic        o_full;
  logic [5:0]  i_alloc_tag = '0;
  logic [31:0] i_alloc_addr = '0;
  logic [31:0] i_alloc_data = '0;
  logic [3:0]  i_alloc_width = '0;
  logic        i_alloc_en = 1'b0;
  logic [5:0]  i_rob_retire_tag = '0;
  logic        i_rob_retire_en = 1'b0;
  logic [31:0] o_mem_wr_addr;
  logic [31:0] o_mem_wr_data;
  logic [3:0]  o_mem_wr_byte_en;
  logic        o_mem_wr_valid;
  logic        i_mem_wr_ready = 1'b1;
  logic [31:0] o_sq_retire_addr;
  logic [3:0]  o_sq_retire_width;
  logic        o_sq_retire_en;

  lsu_sq dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .o_full(o_full),
    .i_alloc_tag(i_alloc_tag), .i_alloc_addr(i_alloc_addr), .i_alloc_data(i_alloc_data),
    .i_alloc_width(i_alloc_width), .i_alloc_en(i_alloc_en),
    .i_rob_retire_tag(i_rob_retire_tag), .i_rob_retire_en(i_rob_retire_en),
    .o_mem_wr_addr(o_mem_wr_addr), .o_mem_wr_data(o_mem_wr_data),
    .o_mem_wr_byte_en(o_mem_wr_byte_en), .o_mem_wr_valid(o_mem_wr_valid),
    .i_mem_wr_ready(i_mem_wr_ready),
    .o_sq_retire_addr(o_sq_retire_addr), .o_sq_retire_width(o_sq_retire_width),
    .o_sq_retire_en(o_sq_retire_en)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Program-order model: the queue content itself, nothing about pointers or FSM states.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  width;
    logic [5:0]  tag;
    bit          retired;
  } st_t;

  st_t         mq[$];
  logic [5:0]  wlog[$];
  int          hs_cyc[$];
  bit          pend_ret = 0;
  st_t         last_pop;
  bit          prev_stall = 0;

  function automatic int retired_left();
    int n = 0;
    foreach (mq[i]) if (mq[i].retired) n++;
    return n;
  endfunction

  function automatic logic [31:0] exp_addr(input st_t s);
    return s.addr & ~32'd3;
  endfunction
  function automatic logic [31:0] exp_data(input st_t s);
    int off = int'(s.addr & 32'd3);
    return s.data << (8 * off);
  endfunction
  function automatic logic [3:0] exp_be(input st_t s);
    int off = int'(s.addr & 32'd3);
    logic [7:0] m = 8'((1 << s.width) - 1) << off;
    return m[3:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      bit   hs, full_now;
      st_t  keep[$];
      check("full", o_full, (mq.size() == DEPTH));
      check("ret_en", o_sq_retire_en, pend_ret);
      if (pend_ret) begin
        check("ret_addr", o_sq_retire_addr, last_pop.addr);
        check("ret_width", o_sq_retire_width, last_pop.width);
      end
      if (prev_stall) check("hold_valid", o_mem_wr_valid, 1);
      if (o_mem_wr_valid) begin
        if (mq.size() == 0 || !mq[0].retired) begin
          check("wr_head_retired", 0, 1);
        end else begin
          check("wr_addr", o_mem_wr_addr, exp_addr(mq[0]));
          check("wr_data", o_mem_wr_data, exp_data(mq[0]));
          check("wr_be", o_mem_wr_byte_en, exp_be(mq[0]));
        end
      end
      prev_stall = o_mem_wr_valid && !i_mem_wr_ready;
      // Advance the model with the inputs the coming edge will sample.
      hs       = o_mem_wr_valid && i_mem_wr_ready && mq.size() > 0;
      full_now = (mq.size() == DEPTH);
      pend_ret = 0;
      if (hs) begin
        last_pop = mq.pop_front();
        pend_ret = 1;
        wlog.push_back(last_pop.tag);
        hs_cyc.push_back(cyc);
      end
      if (i_rob_retire_en) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (!mq[i].retired && mq[i].tag == i_rob_retire_tag) begin
            mq[i].retired = 1;
            break;
          end
        end
      end
      if (i_flush) begin
        foreach (mq[i]) if (mq[i].retired) keep.push_back(mq[i]);
        mq = keep;
      end else if (i_alloc_en && !full_now) begin
        st_t s;
        s.addr = i_alloc_addr; s.data = i_alloc_data; s.width = i_alloc_width;
        s.tag = i_alloc_tag; s.retired = 0;
        mq.push_back(s);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [5:0] tag, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] width);
    i_alloc_tag = tag; i_alloc_addr = addr; i_alloc_data = data; i_alloc_width = width;
    i_alloc_en = 1'b1;
    step();
    i_alloc_en = 1'b0;
  endtask

  task automatic retire(input logic [5:0] tag);
    i_rob_retire_tag = tag; i_rob_retire_en = 1'b1;
    step();
    i_rob_retire_en = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((retired_left() != 0 || pend_ret || o_mem_wr_valid) && n < 300) begin
      step();
      n++;
    end
    check("drain_in_time", (n < 300), 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!o_mem_wr_valid && n < 50) begin
      step();
      n++;
    end
    check("valid_in_time", (n < 50), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, nw;
    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_full", o_full, 0);
    check("rst_valid", o_mem_wr_valid, 0);
    check("rst_ret_en", o_sq_retire_en, 0);
    check("rst_wr_addr", o_mem_wr_addr, 0);
    check("rst_wr_be", o_mem_wr_byte_en, 0);
    @(posedge clk); #1 rst = 1'b0;
    step();

    // Single store: halfword at 0x1002, minimum drain latency.
    alloc(6'd3, 32'h1002, 32'h0000ABCD, 4'd2);
    retire(6'd3);
    check("lat_n1_valid", o_mem_wr_valid, 0);
    step();
    check("lat_n2_valid", o_mem_wr_valid, 1);
    check("lit_wr_addr", o_mem_wr_addr, 32'h1000);
    check("lit_wr_data", o_mem_wr_data, 32'hABCD0000);
    check("lit_wr_be", o_mem_wr_byte_en, 4'b1100);
    step();
    check("lit_ret_en", o_sq_retire_en, 1);
    check("lit_ret_addr", o_sq_retire_addr, 32'h1002);
    check("lit_ret_width", o_sq_retire_width, 4'd2);
    wait_drain();

    // Fill to full, drop the overflow, free one, refill.
    base = wlog.size();
    for (int i = 0; i < 8; i++) alloc(6'(10 + i), 32'h100 + 32'(4 * i), 32'(32'h11110000 + i), 4'd4);
    check("full_after_8", o_full, 1);
    alloc(6'd18, 32'h200, 32'hDEAD, 4'd4);
    check("full_after_drop", o_full, 1);
    retire(6'd10);
    wait_drain();
    check("not_full_after_pop", o_full, 0);
    alloc(6'd19, 32'h300, 32'hBEEF, 4'd4);
    check("full_after_refill", o_full, 1);
    for (int i = 1; i < 8; i++) retire(6'(10 + i));
    retire(6'd19);
    wait_drain();
    check("full_writes", wlog.size() - base, 9);
    check("full_last_tag", wlog[wlog.size() - 1], 6'd19);

    // Stall: byte store at 0x3001 held for 5 cycles.
    i_mem_wr_ready = 1'b0;
    alloc(6'd40, 32'h3001, 32'h5A, 4'd1);
    retire(6'd40);
    wait_valid();
    nw = wlog.size();
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", o_mem_wr_valid, 1);
      check("stall_addr", o_mem_wr_addr, 32'h3000);
      check("stall_data", o_mem_wr_data, 32'h00005A00);
      check("stall_be", o_mem_wr_byte_en, 4'b0010);
      check("stall_no_ret", o_sq_retire_en, 0);
    end
    i_mem_wr_ready = 1'b1;
    step();
    check("stall_ret_pulse", o_sq_retire_en, 1);
    step();
    check("stall_ret_once", o_sq_retire_en, 0);
    check("stall_one_pop", wlog.size() - nw, 1);

    // Flush: retire 1, then retire 2 together with flush and a (dropped) alloc.
    base = wlog.size();
    i_mem_wr_ready = 1'b0;
    for (int i = 1; i <= 5; i++) alloc(6'(i), 32'h4000 + 32'(4 * i), 32'(32'hA0 + i), 4'd4);
    retire(6'd1);
    i_rob_retire_tag = 6'd2; i_rob_retire_en = 1'b1; i_flush = 1'b1;
    i_alloc_tag = 6'd63; i_alloc_addr = 32'h5000; i_alloc_en = 1'b1;
    step();
    i_rob_retire_en = 1'b0; i_flush = 1'b0; i_alloc_en = 1'b0;
    i_mem_wr_ready = 1'b1;
    wait_drain();
    check("flush_writes", wlog.size() - base, 2);
    alloc(6'd7, 32'h6002, 32'h77, 4'd2);
    retire(6'd7);
    wait_drain();
    check("flush_w0", wlog[base], 6'd1);
    check("flush_w1", wlog[base + 1], 6'd2);
    check("flush_w2", wlog[base + 2], 6'd7);

    // Wrap: 20 rounds of mixed widths and offsets.
    base = wlog.size();
    for (int i = 0; i < 20; i++) begin
      logic [3:0]  w;
      logic [31:0] off;
      w   = (i % 3 == 0) ? 4'd1 : ((i % 3 == 1) ? 4'd2 : 4'd4);
      off = (w == 4'd1) ? 32'(i % 4) : ((w == 4'd2) ? 32'(2 * (i % 2)) : 32'd0);
      alloc(6'(20 + i), 32'h8000 + 32'(16 * i) + off, 32'(32'h01020304 * (i + 1)), w);
      retire(6'(20 + i));
    end
    wait_drain();
    check("wrap_writes", wlog.size() - base, 20);
    check("wrap_first", wlog[base], 6'd20);
    check("wrap_last", wlog[base + 19], 6'd39);

    // Drain spacing for two back-to-back retired stores.
    i_mem_wr_ready = 1'b0;
    alloc(6'd50, 32'h9000, 32'h1, 4'd4);
    alloc(6'd51, 32'h9004, 32'h2, 4'd4);
    retire(6'd50);
    retire(6'd51);
    wait_valid();
    base = hs_cyc.size();
    i_mem_wr_ready = 1'b1;
    wait_drain();
    check("b2b_count", hs_cyc.size() - base, 2);
`ifdef LSU_SQ_B2B_DRAIN_EN
    check("drain_spacing", hs_cyc[base + 1] - hs_cyc[base], 1);
`else
    check("drain_spacing", hs_cyc[base + 1] - hs_cyc[base], 2);
`endif

    repeat (3) step();
    check("end_empty_full", o_full, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
